// File: rtl/riscv_pkg.sv
// Shared definitions for the core memory responder: FSM states and
// unshifted access-size masks as presented by the core.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Expands an unshifted size mask into a bit mask used to zero-extend reads.
   function automatic logic [31:0] size_bitmask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      case (be)
         BE_BYTE: m = 32'h0000_00FF;
         BE_HALF: m = 32'h0000_FFFF;
         BE_WORD: m = 32'hFFFF_FFFF;
         default: for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      endcase
      return m;
   endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// Core-to-memory request/acknowledge bus; the core is the master.
interface core_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [3:0]            mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic                  mem_err;

   modport master (
      output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_rdata, mem_ack, mem_err
   );

   modport slave (
      input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_rdata, mem_ack, mem_err
   );
endinterface

// File: rtl/core_mem_responder_sram_1rw.sv
// Single-port storage with per-byte write enables and combinational read.
module sram_1rw #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 1024,
   localparam int IDX_W      = $clog2(DEPTH),
   localparam int NB         = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic [NB-1:0]         we,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array; contents survive rst and map onto plain RAM.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/core_mem_responder.sv
// Memory responder for a core data port: wait-state FSM, lane steering,
// alignment/range fault detection, backed by sram_1rw.
module core_mem_responder
   import riscv_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          WAIT_STATES = 1
) (
   input logic                 clk,
   input logic                 rst,
   core_mem_responder_if.slave bus
);

   localparam int                    IDX_W   = $clog2(DEPTH_WORDS);
   localparam int                    NB      = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   SPAN    = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
   localparam logic [3:0]            WS_LOAD = 4'(WAIT_STATES - 1);

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  cur_we;
   logic [3:0]            cur_be;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [7:0]            lane_ext;
   logic [ADDR_WIDTH:0]   offset;
   logic                  fault;
   logic                  entering_ack;
   logic [NB-1:0]         sram_we;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_val;

   // With zero wait states the write commits on the latching edge, so the
   // live bus is used in IDLE and the latched copy everywhere else.
   // NOTE: every combinational output gets a value on every path, so no latch forms.
   always_comb begin
      cur_addr     = (state == IDLE) ? bus.mem_addr  : addr_q;
      cur_we       = (state == IDLE) ? bus.mem_we    : we_q;
      cur_be       = (state == IDLE) ? bus.mem_be    : be_q;
      cur_wdata    = (state == IDLE) ? bus.mem_wdata : wdata_q;
      lane_ext     = {4'b0000, cur_be} << cur_addr[1:0];
      offset       = {1'b0, cur_addr} - {1'b0, BASE};
      fault        = (|lane_ext[7:4]) || (offset >= SPAN);
      entering_ack = bus.mem_req &&
                     (((state == IDLE) && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0)));
      sram_we      = {NB{entering_ack && cur_we && !fault && !rst}} & lane_ext[NB-1:0];
      wr_data      = cur_wdata << {cur_addr[1:0], 3'b000};
      rd_val       = (rd_word >> {cur_addr[1:0], 3'b000}) &
                     DATA_WIDTH'(size_bitmask(cur_be));
   end

   sram_1rw #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .addr  (offset[IDX_W+1:2]),
      .wdata (wr_data),
      .rdata (rd_word)
   );

   // NOTE: all state here uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         be_q          <= 4'b0000;
         wdata_q       <= '0;
         bus.mem_ack   <= 1'b0;
         bus.mem_err   <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         bus.mem_ack   <= 1'b0;
         bus.mem_err   <= 1'b0;
         bus.mem_rdata <= '0;
         case (state)
            IDLE: begin
               if (bus.mem_req) begin
                  addr_q  <= bus.mem_addr;
                  we_q    <= bus.mem_we;
                  be_q    <= bus.mem_be;
                  wdata_q <= bus.mem_wdata;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                     cnt   <= WS_LOAD;
                  end else begin
                     state <= ACK;
                  end
               end
            end
            WAIT: begin
               if (!bus.mem_req)      state <= IDLE;
               else if (cnt == 4'd0)  state <= ACK;
               else                   cnt   <= cnt - 4'd1;
            end
            ACK: begin
               bus.mem_ack   <= 1'b1;
               bus.mem_err   <= fault;
               bus.mem_rdata <= (fault || we_q) ? '0 : rd_val;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder at WAIT_STATES of 0, 1 and 3.
module tb_core_mem_responder;
   import riscv_pkg::*;

   typedef struct packed {
      logic        ack;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   core_mem_responder_if bus0 ();
   core_mem_responder_if bus1 ();
   core_mem_responder_if bus3 ();

   core_mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   core_mem_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   core_mem_responder #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input int d, input logic req, input logic we,
                        input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
      case (d)
         0: begin
            bus0.mem_req = req; bus0.mem_we = we; bus0.mem_addr = addr;
            bus0.mem_be = be; bus0.mem_wdata = wd;
         end
         1: begin
            bus1.mem_req = req; bus1.mem_we = we; bus1.mem_addr = addr;
            bus1.mem_be = be; bus1.mem_wdata = wd;
         end
         default: begin
            bus3.mem_req = req; bus3.mem_we = we; bus3.mem_addr = addr;
            bus3.mem_be = be; bus3.mem_wdata = wd;
         end
      endcase
   endtask

   function automatic resp_t sample(input int d);
      resp_t r;
      case (d)
         0:       r = '{bus0.mem_ack, bus0.mem_err, bus0.mem_rdata};
         1:       r = '{bus1.mem_ack, bus1.mem_err, bus1.mem_rdata};
         default: r = '{bus3.mem_ack, bus3.mem_err, bus3.mem_rdata};
      endcase
      return r;
   endfunction

   // Called #1 after a rising edge; returns edges from request sample to ack.
   task automatic run(input string tag, input int d, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
      resp_t r;
      logic  got;
      got = 1'b0; lat = -1; rd = '0; er = 1'b0;
      drive(d, 1'b1, we, addr, be, wd);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         r = sample(d);
         if (r.ack) begin
            got = 1'b1; lat = i - 1; rd = r.rdata; er = r.err;
            drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            break;
         end
      end
      if (!got) begin
         check({tag, "_timeout"}, 32'(got), 32'd1);
         drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      @(posedge clk); #1;
      r = sample(d);
      if (got) check({tag, "_ack_one_cycle"}, 32'(r.ack), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      resp_t       r;
      logic        saw_ack;
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_data [3];
      int          edge_at [3];
      int          e;

      b2b_addr = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018};
      b2b_data = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};
      for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      r = sample(1);
      check("rst_ack",   32'(r.ack), 32'd0);
      check("rst_err",   32'(r.err), 32'd0);
      check("rst_rdata", r.rdata,    32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // WAIT_STATES = 1: word write/read, byte/half lanes, faults
      run("wr_word", 1, 1'b1, 32'h8000_0000, BE_WORD, 32'hDEAD_BEEF, lat, rd, er);
      check("wr_word_lat", 32'(lat), 32'd2);
      check("wr_word_err", 32'(er),  32'd0);
      run("rd_word", 1, 1'b0, 32'h8000_0000, BE_WORD, 32'h0, lat, rd, er);
      check("rd_word_lat",  32'(lat), 32'd2);
      check("rd_word_data", rd,       32'hDEAD_BEEF);
      check("rd_word_err",  32'(er),  32'd0);
      run("wr_byte3", 1, 1'b1, 32'h8000_0003, BE_BYTE, 32'h0000_005A, lat, rd, er);
      check("wr_byte3_err", 32'(er), 32'd0);
      run("rd_word2", 1, 1'b0, 32'h8000_0000, BE_WORD, 32'h0, lat, rd, er);
      check("rd_word2_data", rd, 32'h5AAD_BEEF);
      run("rd_byte3", 1, 1'b0, 32'h8000_0003, BE_BYTE, 32'h0, lat, rd, er);
      check("rd_byte3_data", rd, 32'h0000_005A);
      run("rd_half2", 1, 1'b0, 32'h8000_0002, BE_HALF, 32'h0, lat, rd, er);
      check("rd_half2_data", rd, 32'h0000_5AAD);
      run("rd_half3", 1, 1'b0, 32'h8000_0003, BE_HALF, 32'h0, lat, rd, er);
      check("rd_half3_err",  32'(er), 32'd1);
      check("rd_half3_data", rd,      32'h0);
      run("wr_mis", 1, 1'b1, 32'h8000_0001, BE_WORD, 32'hFFFF_FFFF, lat, rd, er);
      check("wr_mis_err", 32'(er), 32'd1);
      run("rd_word3", 1, 1'b0, 32'h8000_0000, BE_WORD, 32'h0, lat, rd, er);
      check("rd_word3_unchanged", rd, 32'h5AAD_BEEF);
      run("rd_top", 1, 1'b0, 32'h8000_1000, BE_WORD, 32'h0, lat, rd, er);
      check("rd_top_err",  32'(er), 32'd1);
      check("rd_top_data", rd,      32'h0);
      run("rd_below", 1, 1'b0, 32'h7FFF_FFFC, BE_WORD, 32'h0, lat, rd, er);
      check("rd_below_err", 32'(er), 32'd1);
      run("wr_last", 1, 1'b1, 32'h8000_0FFC, BE_WORD, 32'h1234_5678, lat, rd, er);
      check("wr_last_err", 32'(er), 32'd0);
      run("wr_half_hi", 1, 1'b1, 32'h8000_0FFE, BE_HALF, 32'h1234_CAFE, lat, rd, er);
      check("wr_half_hi_err", 32'(er), 32'd0);
      run("rd_last", 1, 1'b0, 32'h8000_0FFC, BE_WORD, 32'h0, lat, rd, er);
      check("rd_last_data", rd, 32'hCAFE_5678);

      // WAIT_STATES = 0: preload, then three reads with req held high
      for (int k = 0; k < 3; k++) begin
         run("wr_ws0", 0, 1'b1, b2b_addr[k], BE_WORD, b2b_data[k], lat, rd, er);
         check("wr_ws0_lat", 32'(lat), 32'd1);
      end
      drive(0, 1'b1, 1'b0, b2b_addr[0], BE_WORD, 32'h0);
      e = 0;
      for (int k = 0; k < 3; k++) begin
         edge_at[k] = -1;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            e++;
            r = sample(0);
            if (r.ack) begin
               edge_at[k] = e;
               check("b2b_data", r.rdata, b2b_data[k]);
               check("b2b_err",  32'(r.err), 32'd0);
               if (k < 2) drive(0, 1'b1, 1'b0, b2b_addr[k+1], BE_WORD, 32'h0);
               else       drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
               break;
            end
         end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("b2b_first_edge", 32'(edge_at[0]),              32'd2);
      check("b2b_spacing_1",  32'(edge_at[1] - edge_at[0]), 32'd2);
      check("b2b_spacing_2",  32'(edge_at[2] - edge_at[1]), 32'd2);
      @(posedge clk); #1;

      // WAIT_STATES = 3: reset during WAIT, then abort by dropping req
      run("wr_old", 3, 1'b1, 32'h8000_0020, BE_WORD, 32'h1111_1111, lat, rd, er);
      check("wr_old_lat", 32'(lat), 32'd4);
      drive(3, 1'b1, 1'b1, 32'h8000_0020, BE_WORD, 32'h2222_2222);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      r = sample(3);
      saw_ack = r.ack;
      repeat (4) begin @(posedge clk); #1; r = sample(3); saw_ack |= r.ack; end
      drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; r = sample(3); saw_ack |= r.ack; end
      check("rst_wait_no_ack", 32'(saw_ack), 32'd0);
      run("rd_after_rst", 3, 1'b0, 32'h8000_0020, BE_WORD, 32'h0, lat, rd, er);
      check("rd_after_rst_data", rd, 32'h1111_1111);

      drive(3, 1'b1, 1'b1, 32'h8000_0020, BE_WORD, 32'h3333_3333);
      repeat (2) begin @(posedge clk); #1; end
      drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      saw_ack = 1'b0;
      repeat (6) begin @(posedge clk); #1; r = sample(3); saw_ack |= r.ack; end
      check("abort_no_ack", 32'(saw_ack), 32'd0);
      run("rd_after_abort", 3, 1'b0, 32'h8000_0020, BE_WORD, 32'h0, lat, rd, er);
      check("rd_after_abort_data", rd, 32'h1111_1111);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
